// File: rtl/ex_mem_pipe_pkg.sv
// ============================================================================
// Module   : ex_mem_pipe_pkg
// Brief    : Shared EX/MEM constants, payload record and skid-buffer states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ex_mem_pipe_pkg;

  localparam int CORE_XLEN = 32;
  localparam int CORE_REGW = 5;

  // Load/store access size and sign encodings carried in funct3
  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  typedef struct packed {
    logic [CORE_XLEN-1:0] alu_result;
    logic [CORE_XLEN-1:0] store_data;
    logic [CORE_REGW-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic [2:0]           funct3;
  } ex_mem_payload_t;

  localparam int EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic f3_is_unsigned(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_pipe_skid2.sv
// ============================================================================
// Module   : pipe_skid2
// Brief    : Generic 2-entry skid buffer on a flat payload with flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_skid2
  import ex_mem_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occupancy
);

  skid_state_e  r_state;
  skid_state_e  w_state_nxt;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_ready;

  logic w_acc;
  logic w_deq;
  logic w_main_valid;
  logic w_skid_valid;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_main_valid = (r_state == ST_ONE) || (r_state == ST_FULL);
  assign w_skid_valid = (r_state == ST_FULL);
  assign w_acc        = i_valid & r_ready;
  assign w_deq        = w_main_valid & i_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && w_deq) begin
          w_load_main_in = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_deq) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_deq) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush squashes both entries; any pending acceptance is dropped
    if (i_flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Ready is registered so EX never sees a combinational path from MEM
      r_ready <= (w_state_nxt != ST_FULL);
      if (w_load_main_in) begin
        r_main <= i_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = w_main_valid;
  assign o_data      = r_main;
  assign o_occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule

`default_nettype wire

// File: rtl/ex_mem_pipe.sv
// ============================================================================
// Module   : ex_mem_pipe
// Brief    : EX/MEM pipeline stage: skid-buffered payload plus forwarding taps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter int REGW = CORE_REGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_mem_to_reg,
  input  logic [2:0]      ex_funct3,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [REGW-1:0] mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_mem_to_reg,
  output logic [2:0]      mem_funct3,
  output logic [REGW-1:0] exmem_regRD,
  output logic            exmem_regWrite,
  output logic [XLEN-1:0] exmem_fwd_data,
  output logic [1:0]      occupancy
);

  ex_mem_payload_t w_in_pl;
  ex_mem_payload_t w_head;
  logic            w_head_valid;

  always_comb begin
    w_in_pl            = '0;
    w_in_pl.alu_result = ex_alu_result;
    w_in_pl.store_data = ex_store_data;
    w_in_pl.rd         = ex_rd;
    w_in_pl.reg_write  = ex_reg_write;
    w_in_pl.mem_read   = ex_mem_read;
    w_in_pl.mem_write  = ex_mem_write;
    w_in_pl.mem_to_reg = ex_mem_to_reg;
    w_in_pl.funct3     = ex_funct3;
  end

  pipe_skid2 #(
    .W (EX_MEM_PAYLOAD_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_valid     (ex_valid),
    .o_ready     (ex_ready),
    .i_data      (w_in_pl),
    .o_valid     (w_head_valid),
    .i_ready     (mem_ready),
    .o_data      (w_head),
    .o_occupancy (occupancy)
  );

  assign mem_valid      = w_head_valid;
  assign mem_alu_result = w_head.alu_result;
  assign mem_store_data = w_head.store_data;
  assign mem_rd         = w_head.rd;
  assign mem_mem_to_reg = w_head.mem_to_reg;
  assign mem_funct3     = w_head.funct3;

  // Side-effecting controls are masked so a stale head can never act
  assign mem_reg_write  = w_head_valid & w_head.reg_write;
  assign mem_mem_read   = w_head_valid & w_head.mem_read;
  assign mem_mem_write  = w_head_valid & w_head.mem_write;

  assign exmem_regRD    = w_head.rd;
  assign exmem_fwd_data = w_head.alu_result;
  assign exmem_regWrite = w_head_valid & w_head.reg_write & (w_head.rd != '0);

endmodule

`default_nettype wire
